// File: rtl/data_memory_if.sv
// CPU data-side memory bus: request strobes, address and data in both directions.
// Combinational bundle only; no latency of its own.
// Requester holds the strobes until ready; completer raises ready for one cycle.
interface data_memory_if;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mem_read;
    logic        mem_write;
    logic        ready;
    logic        fault;

    modport master (
        output data_addr, data_in, mem_read, mem_write,
        input  data_out, ready, fault
    );

    modport slave (
        input  data_addr, data_in, mem_read, mem_write,
        output data_out, ready, fault
    );
endinterface

// File: rtl/data_memory.sv
// Word-addressed data RAM behind the CPU data port; rejects illegal requests with fault.
// Latency: ready pulses WAIT_STATES+1 cycles after acceptance; one access per WAIT_STATES+2 cycles.
// Backpressure: requester holds strobes until ready; strobes are ignored while an access is in flight.
module data_memory #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic [31:0] data_out_q, data_out_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      offset;
    logic [31:0]      index;
    logic [IDX_W-1:0] mem_idx;
    logic             req_fault;
    logic             mem_we;

    // Decode the latched request: wrap-around offset from the base, then range/alignment/strobe checks.
    always_comb begin
        offset    = addr_q - ADDR_BASE;
        index     = offset >> 2;
        mem_idx   = index[IDX_W-1:0];
        req_fault = (rd_q & wr_q) | (addr_q[1:0] != 2'b00) | (index >= 32'(DEPTH_WORDS));
    end

    // Next-state logic; the RESP cycle commits the access so ready/data_out/write land on the same edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        ready_d    = 1'b0;
        fault_d    = 1'b0;
        data_out_d = data_out_q;
        mem_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_read | bus.mem_write) begin
                    addr_d = bus.data_addr;
                    wdat_d = bus.data_in;
                    rd_d   = bus.mem_read;
                    wr_d   = bus.mem_write;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 3'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                fault_d = req_fault;
                if (!req_fault) begin
                    if (wr_q) begin
                        mem_we = 1'b1;
                    end
                    if (rd_q) begin
                        data_out_d = mem[mem_idx];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any access in flight without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= 32'd0;
            wdat_q     <= 32'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
            data_out_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
            data_out_q <= data_out_d;
        end
    end

    // RAM array write port; contents survive reset, but a write colliding with reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_idx] <= wdat_q;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.ready    = ready_q;
    assign bus.fault    = fault_q;
endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: three instances with different depth/base/wait-state settings.
// Table of directed vectors, hand sequences for timing/reset corners, then random traffic vs a model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_data_memory;
    localparam int          W_A = 1, W_B = 0, W_C = 7;
    localparam logic [31:0] BASE_A = 32'h0, BASE_B = 32'h1000, BASE_C = 32'h0;
    localparam int          DEP_A = 256, DEP_B = 256, DEP_C = 16;

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    data_memory_if if_a ();
    data_memory_if if_b ();
    data_memory_if if_c ();

    data_memory #(.DEPTH_WORDS(DEP_A), .ADDR_BASE(BASE_A), .WAIT_STATES(W_A))
        u_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));
    data_memory #(.DEPTH_WORDS(DEP_B), .ADDR_BASE(BASE_B), .WAIT_STATES(W_B))
        u_b (.clk(clk), .rst(rst_b), .bus(if_b.slave));
    data_memory #(.DEPTH_WORDS(DEP_C), .ADDR_BASE(BASE_C), .WAIT_STATES(W_C))
        u_c (.clk(clk), .rst(rst_c), .bus(if_c.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] mdl_mem  [3][4096];
    bit          mdl_vld  [3][4096];
    logic [31:0] mdl_dout [3];
    bit          mdl_dk   [3];

    function automatic int w_of(int sel);
        return (sel == 0) ? W_A : (sel == 1) ? W_B : W_C;
    endfunction
    function automatic logic [31:0] base_of(int sel);
        return (sel == 0) ? BASE_A : (sel == 1) ? BASE_B : BASE_C;
    endfunction
    function automatic int depth_of(int sel);
        return (sel == 0) ? DEP_A : (sel == 1) ? DEP_B : DEP_C;
    endfunction

    task automatic model_step(input int sel, input logic [31:0] addr, input bit rd, input bit wr,
                              input logic [31:0] wdat, output bit f, output logic [31:0] d,
                              output bit dk);
        logic [31:0] off;
        int idx;
        off = addr - base_of(sel);
        f = (rd && wr) || (addr % 4 != 0) || (off / 32'd4 >= 32'(depth_of(sel)));
        if (!f) begin
            idx = int'(off / 32'd4);
            if (wr) begin
                mdl_mem[sel][idx] = wdat;
                mdl_vld[sel][idx] = 1'b1;
            end else begin
                mdl_dout[sel] = mdl_mem[sel][idx];
                mdl_dk[sel]   = mdl_vld[sel][idx];
            end
        end
        d  = mdl_dout[sel];
        dk = mdl_dk[sel];
    endtask

    // ---------------- bench helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [31:0] addr, input bit rd, input bit wr,
                         input logic [31:0] wdat);
        case (sel)
            0: begin if_a.data_addr = addr; if_a.mem_read = rd; if_a.mem_write = wr; if_a.data_in = wdat; end
            1: begin if_b.data_addr = addr; if_b.mem_read = rd; if_b.mem_write = wr; if_b.data_in = wdat; end
            default: begin if_c.data_addr = addr; if_c.mem_read = rd; if_c.mem_write = wr; if_c.data_in = wdat; end
        endcase
    endtask

    task automatic sample(input int sel, output bit r, output bit f, output logic [31:0] d);
        case (sel)
            0: begin r = if_a.ready; f = if_a.fault; d = if_a.data_out; end
            1: begin r = if_b.ready; f = if_b.fault; d = if_b.data_out; end
            default: begin r = if_c.ready; f = if_c.fault; d = if_c.data_out; end
        endcase
    endtask

    // Issue one request at the current falling edge; drop strobes in the ready cycle.
    // lat counts falling edges after issue until ready is seen (expected W+2).
    task automatic xact(input int sel, input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [31:0] wdat, output bit f, output logic [31:0] d,
                        output int lat, output int rcyc);
        bit r;
        lat  = -1;
        rcyc = 0;
        f    = 1'b0;
        d    = 32'd0;
        drive(sel, addr, rd, wr, wdat);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            sample(sel, r, f, d);
            if (r) begin
                lat  = n;
                rcyc = cyc;
                drive(sel, 32'd0, 1'b0, 1'b0, 32'd0);
                break;
            end
            chk("fault_without_ready", {31'd0, f}, 32'd0);
        end
        if (lat < 0) begin
            drive(sel, 32'd0, 1'b0, 1'b0, 32'd0);
            chk("ready_timeout", 32'hFFFF_FFFF, 32'(w_of(sel) + 2));
        end
    endtask

    // Model-checked transaction: latency, fault and data_out against the reference model.
    task automatic run_model(input string name, input int sel, input logic [31:0] addr,
                             input bit rd, input bit wr, input logic [31:0] wdat);
        bit ef, dk, f;
        logic [31:0] ed, d;
        int lat, rc;
        model_step(sel, addr, rd, wr, wdat, ef, ed, dk);
        xact(sel, addr, rd, wr, wdat, f, d, lat, rc);
        chk({name, "_lat"}, 32'(lat), 32'(w_of(sel) + 2));
        chk({name, "_fault"}, {31'd0, f}, {31'd0, ef});
        if (dk) chk({name, "_dout"}, d, ed);
    endtask

    // Hold mem_read through ready and check the re-acceptance spacing.
    task automatic held_read(input string name, input int sel, input logic [31:0] addr);
        bit r, f, ef, dk;
        logic [31:0] d, ed;
        int first, second;
        first  = -1;
        second = -1;
        model_step(sel, addr, 1'b1, 1'b0, 32'd0, ef, ed, dk);
        drive(sel, addr, 1'b1, 1'b0, 32'd0);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            sample(sel, r, f, d);
            if (r) begin
                if (dk) chk({name, "_dout"}, d, ed);
                if (first < 0) begin
                    first = n;
                end else begin
                    second = n;
                    drive(sel, 32'd0, 1'b0, 1'b0, 32'd0);
                    break;
                end
            end
        end
        drive(sel, 32'd0, 1'b0, 1'b0, 32'd0);
        chk({name, "_first"}, 32'(first), 32'(w_of(sel) + 2));
        chk({name, "_second"}, 32'(second), 32'(2 * (w_of(sel) + 2)));
        @(negedge clk);
        sample(sel, r, f, d);
        chk({name, "_no_third"}, {31'd0, r}, 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          sel;
        logic [31:0] addr;
        bit          rd;
        bit          wr;
        logic [31:0] wdat;
        bit          ef;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(int sel, logic [31:0] addr, bit rd, bit wr, logic [31:0] wdat,
                                bit ef, logic [31:0] ed);
        vec_t v;
        v.sel = sel; v.addr = addr; v.rd = rd; v.wr = wr; v.wdat = wdat; v.ef = ef; v.ed = ed;
        return v;
    endfunction

    initial begin
        bit r, f, ef, dk;
        logic [31:0] d, ed, ra, rw;
        bit rrd, rwr;
        int lat, lat2, rc1, rc2, saw;

        tbl[0]  = mk(0, 32'h10,   0, 1, 32'hDEADBEEF, 0, 32'h0);
        tbl[1]  = mk(0, 32'h10,   1, 0, 32'h0,        0, 32'hDEADBEEF);
        tbl[2]  = mk(0, 32'h13,   1, 0, 32'h0,        1, 32'hDEADBEEF);
        tbl[3]  = mk(0, 32'h10,   1, 1, 32'h12345678, 1, 32'hDEADBEEF);
        tbl[4]  = mk(0, 32'h12,   0, 1, 32'h99999999, 1, 32'hDEADBEEF);
        tbl[5]  = mk(0, 32'h10,   1, 0, 32'h0,        0, 32'hDEADBEEF);
        tbl[6]  = mk(0, 32'h0,    0, 1, 32'hCAFE0000, 0, 32'hDEADBEEF);
        tbl[7]  = mk(0, 32'h400,  0, 1, 32'h0BAD0BAD, 1, 32'hDEADBEEF);
        tbl[8]  = mk(0, 32'h0,    1, 0, 32'h0,        0, 32'hCAFE0000);
        tbl[9]  = mk(0, 32'h3FC,  0, 1, 32'hA5A5A5A5, 0, 32'hCAFE0000);
        tbl[10] = mk(0, 32'h3FC,  1, 0, 32'h0,        0, 32'hA5A5A5A5);
        tbl[11] = mk(1, 32'h1000, 0, 1, 32'h11111111, 0, 32'h0);
        tbl[12] = mk(1, 32'h1004, 0, 1, 32'h22222222, 0, 32'h0);
        tbl[13] = mk(1, 32'h13FC, 0, 1, 32'h13FC13FC, 0, 32'h0);
        tbl[14] = mk(1, 32'h1400, 0, 1, 32'h0BAD0BAD, 1, 32'h0);
        tbl[15] = mk(1, 32'h0FFC, 1, 0, 32'h0,        1, 32'h0);
        tbl[16] = mk(1, 32'h1000, 1, 0, 32'h0,        0, 32'h11111111);
        tbl[17] = mk(1, 32'h13FC, 1, 0, 32'h0,        0, 32'h13FC13FC);

        for (int s = 0; s < 3; s++) begin
            mdl_dout[s] = 32'd0;
            mdl_dk[s]   = 1'b1;
            drive(s, 32'd0, 1'b0, 1'b0, 32'd0);
        end

        // Reset all instances, then check reset values.
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sample(s, r, f, d);
            chk($sformatf("reset%0d_ready", s), {31'd0, r}, 32'd0);
            chk($sformatf("reset%0d_fault", s), {31'd0, f}, 32'd0);
            chk($sformatf("reset%0d_dout", s), d, 32'd0);
        end

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            model_step(tbl[i].sel, tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wdat, ef, ed, dk);
            xact(tbl[i].sel, tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wdat, f, d, lat, rc1);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(w_of(tbl[i].sel) + 2));
            chk($sformatf("tbl%0d_fault", i), {31'd0, f}, {31'd0, tbl[i].ef});
            chk($sformatf("tbl%0d_dout", i), d, tbl[i].ed);
        end

        // Zero-wait back-to-back reads: one ready every two cycles.
        model_step(1, 32'h1000, 1'b1, 1'b0, 32'd0, ef, ed, dk);
        xact(1, 32'h1000, 1'b1, 1'b0, 32'd0, f, d, lat, rc1);
        chk("b2b_first_dout", d, 32'h11111111);
        model_step(1, 32'h1004, 1'b1, 1'b0, 32'd0, ef, ed, dk);
        xact(1, 32'h1004, 1'b1, 1'b0, 32'd0, f, d, lat2, rc2);
        chk("b2b_second_dout", d, 32'h22222222);
        chk("b2b_interval", 32'(rc2 - rc1), 32'd2);

        // Held strobe re-acceptance on the one-wait instance.
        held_read("held_a", 0, 32'h10);

        // Reset during a seven-wait write: no response, old contents kept.
        run_model("c_prep_wr", 2, 32'h8, 1'b0, 1'b1, 32'h0000AAAA);
        run_model("c_prep_rd", 2, 32'h8, 1'b1, 1'b0, 32'h0);
        saw = 0;
        drive(2, 32'h8, 1'b0, 1'b1, 32'h00005555);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            sample(2, r, f, d);
            if (r) saw++;
        end
        rst_c = 1'b1;
        drive(2, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rst_c = 1'b0;
        sample(2, r, f, d);
        chk("midrst_ready", {31'd0, r}, 32'd0);
        chk("midrst_fault", {31'd0, f}, 32'd0);
        chk("midrst_dout", d, 32'd0);
        mdl_dout[2] = 32'd0;
        mdl_dk[2]   = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            sample(2, r, f, d);
            if (r) saw++;
        end
        chk("midrst_no_ready", 32'(saw), 32'd0);
        run_model("midrst_readback", 2, 32'h8, 1'b1, 1'b0, 32'h0);
        chk("midrst_readback_val", mdl_dout[2], 32'h0000AAAA);

        held_read("held_c", 2, 32'h8);

        // Random traffic on all instances against the reference model.
        for (int i = 0; i < 150; i++) begin
            int sel, roll, idx;
            sel  = $urandom_range(0, 2);
            roll = $urandom_range(0, 15);
            if (roll < 10) idx = $urandom_range(0, 15);
            else           idx = $urandom_range(0, depth_of(sel) + 3);
            ra = base_of(sel) + 32'(idx) * 32'd4;
            if (roll == 11) ra = base_of(sel) - 32'd4;
            if ($urandom_range(0, 7) == 0) ra = ra + 32'($urandom_range(1, 3));
            roll = $urandom_range(0, 9);
            rrd  = (roll <= 5);
            rwr  = (roll >= 5);
            rw   = $urandom;
            run_model($sformatf("rand%0d", i), sel, ra, rrd, rwr, rw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
